// File: rtl/elevator_dispatch_core.sv
// Call latching and collective-selective direction/stop decision for a car
// serving FLOORS floors; floor f maps to bit f-1 of every call vector.
module elevator_dispatch_core #(
  parameter int FLOORS  = 7,
  parameter int FLOOR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic [1:0]         current_dir,
  input  logic [FLOORS-1:0]  hall_up,
  input  logic [FLOORS-1:0]  hall_dn,
  input  logic [FLOORS-1:0]  cab,
  input  logic               door_open,
  input  logic               move,
  output logic [1:0]         next_dir,
  output logic               stop_here,
  output logic [FLOORS-1:0]  pend_up,
  output logic [FLOORS-1:0]  pend_dn,
  output logic [FLOORS-1:0]  pend_cab,
  output logic               any_call,
  output logic               floor_err
);

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_DN   = 2'b01,
    DIR_UP   = 2'b10,
    DIR_BAD  = 2'b11
  } dir_t;

  localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  dir_t              dir, dir_q, dir_dec;
  logic              legal, above, below, up_f, dn_f, cab_f, stop_nxt;
  logic [FLOORS-1:0] at_f, above_m, below_m, all_pend;
  logic [FLOORS-1:0] clr_up, clr_dn, clr_cab, nxt_up, nxt_dn, nxt_cab;

  assign dir      = dir_t'(current_dir);
  assign next_dir = dir_q;

  // at_f is all-zero on an illegal floor, which suppresses every clear
  always_comb begin
    legal = (current_floor != '0) && (current_floor <= FLOOR_W'(FLOORS));
    for (int unsigned i = 0; i < FLOORS; i++) begin
      at_f[i]    = legal && (current_floor == FLOOR_W'(i + 1));
      above_m[i] = FLOOR_W'(i) >= current_floor;
      below_m[i] = FLOOR_W'(i + 1) < current_floor;
    end
    all_pend = pend_up | pend_dn | pend_cab;
    above    = |(all_pend & above_m);
    below    = |(all_pend & below_m);
    up_f     = |(pend_up & at_f);
    dn_f     = |(pend_dn & at_f);
    cab_f    = |(pend_cab & at_f);
  end

  always_comb begin
    clr_up  = '0;
    clr_dn  = '0;
    clr_cab = door_open ? at_f : '0;
    if (door_open) begin
      case (dir)
        DIR_UP: begin
          clr_up = at_f;
          if (!above) clr_dn = at_f;
        end
        DIR_DN: begin
          clr_dn = at_f;
          if (!below) clr_up = at_f;
        end
        DIR_STOP: begin
          clr_up = at_f;
          clr_dn = at_f;
        end
        default: ;
      endcase
    end
    nxt_up  = ((pend_up & ~clr_up) | hall_up) & UP_MASK;
    nxt_dn  = ((pend_dn & ~clr_dn) | hall_dn) & DN_MASK;
    nxt_cab = (pend_cab & ~clr_cab) | cab;
  end

  always_comb begin
    stop_nxt = legal && (cab_f
      || (dir == DIR_UP && (up_f || (!above && dn_f) || current_floor == FLOOR_W'(FLOORS)))
      || (dir == DIR_DN && (dn_f || (!below && up_f) || current_floor == FLOOR_W'(1)))
      || (dir == DIR_STOP && (up_f || dn_f)));
  end

  always_comb begin
    dir_dec = dir_q;
    case (dir)
      DIR_STOP, DIR_UP: dir_dec = above ? DIR_UP : (below ? DIR_DN : DIR_STOP);
      DIR_DN:           dir_dec = below ? DIR_DN : (above ? DIR_UP : DIR_STOP);
      default:          dir_dec = dir_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q     <= DIR_STOP;
      stop_here <= 1'b0;
      pend_up   <= '0;
      pend_dn   <= '0;
      pend_cab  <= '0;
      any_call  <= 1'b0;
      floor_err <= 1'b0;
    end else begin
      pend_up   <= nxt_up;
      pend_dn   <= nxt_dn;
      pend_cab  <= nxt_cab;
      any_call  <= |(nxt_up | nxt_dn | nxt_cab);
      stop_here <= stop_nxt;
      if (!legal || dir == DIR_BAD) floor_err <= 1'b1;
      // illegal floor or direction freezes the decision even with enable low
      if (!legal || dir == DIR_BAD) dir_q <= dir_q;
      else if (!enable)             dir_q <= dir;
      else if (!move && !door_open) dir_q <= dir_dec;
    end
  end

endmodule

// File: tb/tb_elevator_dispatch_core.sv
// Directed-vector bench for elevator_dispatch_core with FLOORS=7.
module tb_elevator_dispatch_core;

  logic       clk = 1'b0;
  logic       reset, enable, door_open, move;
  logic [3:0] current_floor;
  logic [1:0] current_dir;
  logic [6:0] hall_up, hall_dn, cab;
  logic [1:0] next_dir;
  logic       stop_here, any_call, floor_err;
  logic [6:0] pend_up, pend_dn, pend_cab;
  int         vectors = 0;
  int         errs = 0;

  elevator_dispatch_core #(.FLOORS(7), .FLOOR_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .current_floor(current_floor),
    .current_dir(current_dir), .hall_up(hall_up), .hall_dn(hall_dn), .cab(cab),
    .door_open(door_open), .move(move), .next_dir(next_dir), .stop_here(stop_here),
    .pend_up(pend_up), .pend_dn(pend_dn), .pend_cab(pend_cab), .any_call(any_call),
    .floor_err(floor_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b1; door_open = 1'b0; move = 1'b0;
    current_floor = 4'd2; current_dir = 2'b00;
    hall_up = '0; hall_dn = '0; cab = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    vectors++; if (next_dir !== 2'b00) begin errs++; $display("FAIL rst_next_dir got %b expected 00", next_dir); end
    vectors++; if (stop_here !== 1'b0) begin errs++; $display("FAIL rst_stop_here got %b expected 0", stop_here); end
    vectors++; if ({pend_up, pend_dn, pend_cab} !== 21'd0) begin errs++; $display("FAIL rst_pend got %b %b %b expected all 0", pend_up, pend_dn, pend_cab); end
    vectors++; if (any_call !== 1'b0) begin errs++; $display("FAIL rst_any_call got %b expected 0", any_call); end
    vectors++; if (floor_err !== 1'b0) begin errs++; $display("FAIL rst_floor_err got %b expected 0", floor_err); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_cab_up();
    do_reset();
    cab = 7'b0010000;
    tick();
    cab = '0;
    vectors++; if (pend_cab !== 7'b0010000) begin errs++; $display("FAIL cab_latch got %b expected 0010000", pend_cab); end
    vectors++; if (any_call !== 1'b1) begin errs++; $display("FAIL cab_any_call got %b expected 1", any_call); end
    vectors++; if (next_dir !== 2'b00) begin errs++; $display("FAIL cab_dir_first got %b expected 00", next_dir); end
    tick();
    vectors++; if (next_dir !== 2'b10) begin errs++; $display("FAIL cab_dir_up got %b expected 10", next_dir); end
    vectors++; if (stop_here !== 1'b0) begin errs++; $display("FAIL cab_no_stop got %b expected 0", stop_here); end
  endtask

  task automatic test_clear_up();
    do_reset();
    current_floor = 4'd3; current_dir = 2'b10; move = 1'b1;
    hall_up = 7'b0000100; hall_dn = 7'b0000100; cab = 7'b0100000;
    tick();
    hall_up = '0; hall_dn = '0; cab = '0;
    tick();
    vectors++; if (stop_here !== 1'b1) begin errs++; $display("FAIL clr_stop_before got %b expected 1", stop_here); end
    door_open = 1'b1;
    tick();
    vectors++; if (pend_up !== 7'b0000000) begin errs++; $display("FAIL clr_pend_up got %b expected 0000000", pend_up); end
    vectors++; if (pend_dn !== 7'b0000100) begin errs++; $display("FAIL clr_pend_dn_kept got %b expected 0000100", pend_dn); end
    vectors++; if (pend_cab !== 7'b0100000) begin errs++; $display("FAIL clr_pend_cab got %b expected 0100000", pend_cab); end
    tick();
    vectors++; if (stop_here !== 1'b0) begin errs++; $display("FAIL clr_stop_after got %b expected 0", stop_here); end
  endtask

  task automatic test_descent();
    do_reset();
    current_floor = 4'd5; current_dir = 2'b10; move = 1'b1; hall_dn = 7'b0000010;
    tick();
    hall_dn = '0; move = 1'b0;
    tick();
    vectors++; if (next_dir !== 2'b01) begin errs++; $display("FAIL desc_dir got %b expected 01", next_dir); end
    current_dir = 2'b01; move = 1'b1; current_floor = 4'd4;
    tick();
    vectors++; if (stop_here !== 1'b0) begin errs++; $display("FAIL desc_stop_f4 got %b expected 0", stop_here); end
    current_floor = 4'd3;
    tick();
    vectors++; if (stop_here !== 1'b0) begin errs++; $display("FAIL desc_stop_f3 got %b expected 0", stop_here); end
    current_floor = 4'd2;
    tick();
    vectors++; if (stop_here !== 1'b1) begin errs++; $display("FAIL desc_stop_f2 got %b expected 1", stop_here); end
    vectors++; if (next_dir !== 2'b01) begin errs++; $display("FAIL desc_dir_hold got %b expected 01", next_dir); end
  endtask

  task automatic test_set_wins();
    do_reset();
    current_floor = 4'd4; current_dir = 2'b10; move = 1'b1; hall_up = 7'b0001000;
    tick();
    door_open = 1'b1;
    tick();
    vectors++; if (pend_up !== 7'b0001000) begin errs++; $display("FAIL setwin_pend_up got %b expected 0001000", pend_up); end
    hall_up = '0;
    tick();
    vectors++; if (pend_up !== 7'b0000000) begin errs++; $display("FAIL setwin_cleared got %b expected 0000000", pend_up); end
  endtask

  task automatic test_enable_off();
    do_reset();
    enable = 1'b0; current_dir = 2'b01; current_floor = 4'd3; cab = 7'b0000001;
    tick();
    vectors++; if (next_dir !== 2'b01) begin errs++; $display("FAIL en_dir_1 got %b expected 01", next_dir); end
    vectors++; if (pend_cab !== 7'b0000001) begin errs++; $display("FAIL en_pend_cab got %b expected 0000001", pend_cab); end
    cab = '0; hall_up = 7'b0100000;
    tick();
    vectors++; if (next_dir !== 2'b01) begin errs++; $display("FAIL en_dir_2 got %b expected 01", next_dir); end
    vectors++; if (pend_up !== 7'b0100000) begin errs++; $display("FAIL en_pend_up got %b expected 0100000", pend_up); end
    hall_up = 7'b1000000; hall_dn = 7'b0000001;
    tick();
    vectors++; if (pend_up !== 7'b0100000) begin errs++; $display("FAIL top_up_wired got %b expected 0100000", pend_up); end
    vectors++; if (pend_dn !== 7'b0000000) begin errs++; $display("FAIL bot_dn_wired got %b expected 0000000", pend_dn); end
    hall_up = '0; hall_dn = '0; current_dir = 2'b00;
    tick();
    vectors++; if (next_dir !== 2'b00) begin errs++; $display("FAIL en_dir_stop got %b expected 00", next_dir); end
  endtask

  task automatic test_end_stops();
    do_reset();
    move = 1'b1; current_floor = 4'd1; current_dir = 2'b01;
    tick();
    vectors++; if (stop_here !== 1'b1) begin errs++; $display("FAIL end_floor1_dn got %b expected 1", stop_here); end
    current_floor = 4'd7; current_dir = 2'b10;
    tick();
    vectors++; if (stop_here !== 1'b1) begin errs++; $display("FAIL end_floor7_up got %b expected 1", stop_here); end
    current_dir = 2'b01;
    tick();
    vectors++; if (stop_here !== 1'b0) begin errs++; $display("FAIL end_floor7_dn got %b expected 0", stop_here); end
  endtask

  task automatic test_floor_err();
    do_reset();
    cab = 7'b0010000;
    tick();
    cab = '0;
    tick();
    current_floor = 4'd0;
    tick();
    vectors++; if (floor_err !== 1'b1) begin errs++; $display("FAIL err_floor0 got %b expected 1", floor_err); end
    vectors++; if (next_dir !== 2'b10) begin errs++; $display("FAIL err_dir_hold0 got %b expected 10", next_dir); end
    vectors++; if (stop_here !== 1'b0) begin errs++; $display("FAIL err_stop0 got %b expected 0", stop_here); end
    current_floor = 4'd9; door_open = 1'b1;
    tick();
    vectors++; if (next_dir !== 2'b10) begin errs++; $display("FAIL err_dir_hold9 got %b expected 10", next_dir); end
    vectors++; if (pend_cab !== 7'b0010000) begin errs++; $display("FAIL err_no_clear got %b expected 0010000", pend_cab); end
    current_floor = 4'd5; door_open = 1'b0; move = 1'b1;
    tick();
    vectors++; if (floor_err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b expected 1", floor_err); end
    vectors++; if (stop_here !== 1'b1) begin errs++; $display("FAIL err_stop_f5 got %b expected 1", stop_here); end
    #3;
    reset = 1'b1;
    #1;
    vectors++; if (next_dir !== 2'b00) begin errs++; $display("FAIL async_dir got %b expected 00", next_dir); end
    vectors++; if ({stop_here, any_call, floor_err} !== 3'b000) begin errs++; $display("FAIL async_flags got %b expected 000", {stop_here, any_call, floor_err}); end
    vectors++; if (pend_cab !== 7'b0000000) begin errs++; $display("FAIL async_pend_cab got %b expected 0000000", pend_cab); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cab_up();
    test_clear_up();
    test_descent();
    test_set_wins();
    test_enable_off();
    test_end_stops();
    test_floor_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
